// File: rtl/drive_seq_pkg.sv
// Shared types for the drive sequencer: state, command and decision encodings.
// The optional search feature is selected by the DRIVE_SEQ_SEARCH_EN macro in drive_seq_ctrl.
package drive_seq_pkg;

    localparam int CONF_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FWD    = 3'd1,
        ST_LEFT   = 3'd2,
        ST_RIGHT  = 3'd3,
        ST_SEARCH = 3'd4,
        ST_FAULT  = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CMD_STOP  = 3'd0,
        CMD_FWD   = 3'd1,
        CMD_LEFT  = 3'd2,
        CMD_RIGHT = 3'd3,
        CMD_SPIN  = 3'd4
    } cmd_e;

    typedef enum logic [1:0] {
        DEC_NEUTRAL = 2'd0,
        DEC_FWD     = 2'd1,
        DEC_LEFT    = 2'd2,
        DEC_RIGHT   = 2'd3
    } dec_e;

    function automatic cmd_e state_to_cmd(input state_e s);
        case (s)
            ST_FWD:    return CMD_FWD;
            ST_LEFT:   return CMD_LEFT;
            ST_RIGHT:  return CMD_RIGHT;
            ST_SEARCH: return CMD_SPIN;
            default:   return CMD_STOP;
        endcase
    endfunction

endpackage

// File: rtl/drive_seq_debounce.sv
// N-frame confirmer: a decision is confirmed once it has been seen on CONFIRM_FRAMES
// consecutive ticks. Confirmation is combinational on the tick that completes the run.
module drive_seq_debounce
    import drive_seq_pkg::*;
#(
    parameter int CONFIRM_FRAMES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  dec_e dec,
    input  logic clear,
    output logic confirmed,
    output dec_e conf_dec
);

    localparam logic [CONF_CNT_W-1:0] CONFIRM_LIM = CONF_CNT_W'(CONFIRM_FRAMES);

    dec_e                  r_cand;
    logic [CONF_CNT_W-1:0] r_cnt;
    logic [CONF_CNT_W-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = CONF_CNT_W'(1);
        if (dec == r_cand) begin
            w_cnt_next = (r_cnt >= CONFIRM_LIM) ? CONFIRM_LIM : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (tick && clear)) begin
            r_cand <= DEC_NEUTRAL;
            r_cnt  <= '0;
        end else if (tick) begin
            r_cand <= dec;
            r_cnt  <= w_cnt_next;
        end
    end

    assign confirmed = tick && !clear && (w_cnt_next == CONFIRM_LIM);
    assign conf_dec  = dec;

endmodule

// File: rtl/drive_seq_ctrl.sv
// Frame-rate drive sequencer: debounced steering decisions, one motor command per state
// change over valid/ready, and a frame watchdog. Define DRIVE_SEQ_SEARCH_EN to add ST_SEARCH.
module drive_seq_ctrl
    import drive_seq_pkg::*;
#(
    parameter int CONFIRM_FRAMES = 3,
    parameter int LOST_FRAMES    = 8,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       turn_left,
    input  logic       turn_right,
    input  logic       centered,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] drive_state,
    output logic       fault
);

    localparam int             WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    state_e          r_state;
    state_e          w_next_state;
    cmd_e            r_cmd;
    logic            r_cmd_valid;
    logic [WD_W-1:0] r_wd;
    dec_e            w_dec;
    dec_e            w_conf_dec;
    logic            w_confirmed;
    logic            w_clear;
    logic            w_timeout;
    logic            w_lost;

    always_comb begin
        w_dec = DEC_NEUTRAL;
        if (centered) begin
            w_dec = DEC_FWD;
        end else if (turn_left && !turn_right) begin
            w_dec = DEC_LEFT;
        end else if (turn_right && !turn_left) begin
            w_dec = DEC_RIGHT;
        end
    end

    // Leaving FAULT restarts debounce from scratch; the exit tick's decision is discarded.
    assign w_clear   = frame_tick && (r_state == ST_FAULT);
    assign w_timeout = !frame_tick && (r_wd >= WD_LAST);

    drive_seq_debounce #(
        .CONFIRM_FRAMES(CONFIRM_FRAMES)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .tick     (frame_tick),
        .dec      (w_dec),
        .clear    (w_clear),
        .confirmed(w_confirmed),
        .conf_dec (w_conf_dec)
    );

`ifdef DRIVE_SEQ_SEARCH_EN
    logic [7:0] r_neutral_run;
    logic [7:0] w_run_next;

    always_comb begin
        w_run_next = '0;
        if (w_dec == DEC_NEUTRAL) begin
            w_run_next = (r_neutral_run == 8'hFF) ? r_neutral_run : r_neutral_run + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_neutral_run <= '0;
        end else if (frame_tick) begin
            r_neutral_run <= w_run_next;
        end
    end

    assign w_lost = frame_tick && !w_clear && (w_dec == DEC_NEUTRAL)
                    && (w_run_next >= 8'(LOST_FRAMES));
`else
    logic w_unused_lost_cfg;
    assign w_unused_lost_cfg = (LOST_FRAMES > 0);
    assign w_lost            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (r_state == ST_FAULT) begin
            if (frame_tick) begin
                w_next_state = ST_IDLE;
            end
        end else if (w_lost) begin
            w_next_state = ST_SEARCH;
        end else if (w_confirmed) begin
            case (w_conf_dec)
                DEC_FWD:   w_next_state = ST_FWD;
                DEC_LEFT:  w_next_state = ST_LEFT;
                DEC_RIGHT: w_next_state = ST_RIGHT;
                default:   w_next_state = ST_IDLE;
            endcase
        end else if (w_timeout) begin
            w_next_state = ST_FAULT;
        end
    end

    // A newer state change overwrites a pending command; the driver only sees the latest.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd       <= CMD_STOP;
            r_cmd_valid <= 1'b0;
        end else if (w_next_state != r_state) begin
            r_cmd       <= state_to_cmd(w_next_state);
            r_cmd_valid <= 1'b1;
        end else if (r_cmd_valid && cmd_ready) begin
            r_cmd_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || frame_tick) begin
            r_wd <= '0;
        end else if (r_wd != WD_MAX) begin
            r_wd <= r_wd + 1'b1;
        end
    end

    assign cmd         = r_cmd;
    assign cmd_valid   = r_cmd_valid;
    assign drive_state = r_state;
    assign fault       = (r_state == ST_FAULT);

endmodule

// File: tb/tb_drive_seq_ctrl.sv
// Self-checking bench for drive_seq_ctrl: a table of per-cycle steps with expected outputs,
// plus a scoreboard of expected handshake commands checked whenever cmd_valid && cmd_ready.
module tb_drive_seq_ctrl;

    localparam int TIMEOUT = 64;

`ifdef DRIVE_SEQ_SEARCH_EN
    localparam int SRCH_ST   = 4;
    localparam int SRCH_CMD  = 4;
    localparam int SRCH_V    = 1;
    localparam int SRCH_PUSH = 4;
`else
    localparam int SRCH_ST   = 0;
    localparam int SRCH_CMD  = 0;
    localparam int SRCH_V    = 0;
    localparam int SRCH_PUSH = -1;
`endif

    typedef struct {
        logic       rst;
        logic       tick;
        logic       c;
        logic       l;
        logic       r;
        logic       rdy;
        logic [2:0] st;
        logic [2:0] cmd;
        logic       v;
        logic       f;
        int         push;
    } step_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       turn_left = 1'b0;
    logic       turn_right = 1'b0;
    logic       centered = 1'b0;
    logic       cmd_ready = 1'b0;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic [2:0] drive_state;
    logic       fault;

    int    checks = 0;
    int    errors = 0;
    int    expQ[$];
    step_t steps[$];

    drive_seq_ctrl #(
        .CONFIRM_FRAMES(3),
        .LOST_FRAMES   (8),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .turn_left  (turn_left),
        .turn_right (turn_right),
        .centered   (centered),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .drive_state(drive_state),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic addStep(input logic rst_, tick_, c_, l_, r_, rdy_,
                           input int st_, cmd_, v_, f_, push_);
        step_t s;
        s.rst  = rst_;
        s.tick = tick_;
        s.c    = c_;
        s.l    = l_;
        s.r    = r_;
        s.rdy  = rdy_;
        s.st   = 3'(st_);
        s.cmd  = 3'(cmd_);
        s.v    = (v_ != 0);
        s.f    = (f_ != 0);
        s.push = push_;
        steps.push_back(s);
    endtask

    // One frame: a tick cycle followed by one idle cycle with the flags still held.
    task automatic addFrame(input logic c_, l_, r_, rdy_, input int st_, cmd_, v_, f_, push_);
        addStep(1'b0, 1'b1, c_, l_, r_, rdy_, st_, cmd_, v_, f_, push_);
        addStep(1'b0, 1'b0, c_, l_, r_, rdy_, st_, cmd_, ((v_ != 0) && !rdy_) ? 1 : 0, f_, -1);
    endtask

    task automatic compare(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %0d want %0d", name, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input step_t s);
        rst        = s.rst;
        frame_tick = s.tick;
        centered   = s.c;
        turn_left  = s.l;
        turn_right = s.r;
        cmd_ready  = s.rdy;
        if (s.push >= 0) expQ.push_back(s.push);
    endtask

    task automatic checkOutput(input step_t s, input int idx);
        compare("drive_state", idx, int'(drive_state), int'(s.st));
        compare("cmd", idx, int'(cmd), int'(s.cmd));
        compare("cmd_valid", idx, int'(cmd_valid), int'(s.v));
        compare("fault", idx, int'(fault), int'(s.f));
    endtask

    // Scoreboard: every accepted command must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL handshake: got cmd %0d want no handshake", cmd);
            end else begin
                int want;
                want = expQ.pop_front();
                if (int'(cmd) != want) begin
                    errors++;
                    $display("[TB] FAIL handshake: got cmd %0d want %0d", cmd, want);
                end
            end
        end
    end

    initial begin
        // Reset values
        addStep(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, -1);
        addStep(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, -1);
        addStep(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, -1);

        // Three centered frames confirm FWD one cycle after the third tick
        addFrame(1, 0, 0, 1, 0, 0, 0, 0, -1);
        addFrame(1, 0, 0, 1, 0, 0, 0, 0, -1);
        addFrame(1, 0, 0, 1, 1, 1, 1, 0, 1);

        // Alternating left/right never confirms
        for (int i = 0; i < 10; i++) begin
            addFrame(0, (i % 2) == 0, (i % 2) == 1, 1, 1, 1, 0, 0, -1);
        end

        // Left and right together decode as NEUTRAL and lead to IDLE
        addFrame(0, 1, 1, 1, 1, 1, 0, 0, -1);
        addFrame(0, 1, 1, 1, 1, 1, 0, 0, -1);
        addFrame(0, 1, 1, 1, 0, 0, 1, 0, 0);

        // Neutral ticks 4..9: SEARCH on the 8th only when the feature is built in
        for (int i = 0; i < 4; i++) begin
            addFrame(0, 0, 0, 1, 0, 0, 0, 0, -1);
        end
        addFrame(0, 0, 0, 1, SRCH_ST, SRCH_CMD, SRCH_V, 0, SRCH_PUSH);
        addFrame(0, 0, 0, 1, SRCH_ST, SRCH_CMD, 0, 0, -1);

        // Ready held low: FWD then RIGHT, latest command wins
        addFrame(1, 0, 0, 0, SRCH_ST, SRCH_CMD, 0, 0, -1);
        addFrame(1, 0, 0, 0, SRCH_ST, SRCH_CMD, 0, 0, -1);
        addFrame(1, 0, 0, 0, 1, 1, 1, 0, -1);
        addFrame(0, 0, 1, 0, 1, 1, 1, 0, -1);
        addFrame(0, 0, 1, 0, 1, 1, 1, 0, -1);
        addFrame(0, 0, 1, 0, 3, 3, 1, 0, -1);
        addStep(0, 0, 0, 0, 1, 1, 3, 3, 0, 0, 3);
        addStep(0, 0, 0, 0, 1, 0, 3, 3, 0, 0, -1);

        // Into LEFT, then watchdog near-miss: tick lands on the exact timeout cycle
        addFrame(0, 1, 0, 1, 3, 3, 0, 0, -1);
        addFrame(0, 1, 0, 1, 3, 3, 0, 0, -1);
        addFrame(0, 1, 0, 1, 2, 2, 1, 0, 2);
        for (int i = 0; i < TIMEOUT - 2; i++) begin
            addStep(0, 0, 0, 1, 0, 1, 2, 2, 0, 0, -1);
        end
        addStep(0, 1, 0, 1, 0, 1, 2, 2, 0, 0, -1);

        // Full timeout enters FAULT with a STOP command
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            addStep(0, 0, 0, 1, 0, 1, 2, 2, 0, 0, -1);
        end
        addStep(0, 0, 0, 1, 0, 1, 5, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            addStep(0, 0, 0, 1, 0, 1, 5, 0, 0, 1, -1);
        end

        // Next tick leaves FAULT and is not counted toward confirmation
        addFrame(1, 0, 0, 1, 0, 0, 1, 0, 0);
        addFrame(1, 0, 0, 1, 0, 0, 0, 0, -1);
        addFrame(1, 0, 0, 1, 0, 0, 0, 0, -1);
        addFrame(1, 0, 0, 1, 1, 1, 1, 0, 1);

        // Reset during a pending command drops it
        addFrame(0, 1, 0, 0, 1, 1, 0, 0, -1);
        addFrame(0, 1, 0, 0, 1, 1, 0, 0, -1);
        addFrame(0, 1, 0, 0, 2, 2, 1, 0, -1);
        addStep(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
        addStep(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, -1);
        addStep(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, -1);

        for (int i = 0; i < steps.size(); i++) begin
            applyStimulus(steps[i]);
            @(posedge clk);
            #1;
            checkOutput(steps[i], i);
        end

        repeat (2) @(posedge clk);
        #1;
        compare("scoreboard_drained", steps.size(), expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/drive_seq_ctrl.md
# drive_seq_ctrl

Frame-rate motion sequencer between the camera steering-flag decision block and the motor driver. Each frame it takes the held decision (`turn_left` / `turn_right` / `centered`) and debounces it over consecutive frames. It runs a drive state machine and issues one motor command per state change over a valid/ready handshake. A watchdog forces a safe stop when frame decisions stop arriving, for example when the camera is lost or the pipeline is stalled.

## Interface
Parameters:
- `CONFIRM_FRAMES`, default 3: consecutive identical decisions needed before a state change. Legal range 1..15.
- `LOST_FRAMES`, default 8: consecutive neutral frames before entering SEARCH. Must be ≥ `CONFIRM_FRAMES`, ≤ 255.
- `TIMEOUT_CYCLES`, default 2_000_000: clk cycles without `frame_tick` before FAULT. This is about 4.8 VGA frames at 25 MHz.

Ports:
- `clk` input, 1 bit: pixel clock. The only clock.
- `rst` input, 1 bit: synchronous, active-high reset.
- `frame_tick` input, 1 bit: one-cycle pulse; the flags are newly updated and stable this cycle.
- `turn_left` input, 1 bit: frame-held decision.
- `turn_right` input, 1 bit: frame-held decision.
- `centered` input, 1 bit: frame-held decision; has priority.
- `cmd` output, 3 bits: motor command code (`drive_seq_pkg::cmd_e`).
- `cmd_valid` output, 1 bit: command pending.
- `cmd_ready` input, 1 bit: motor driver accepts `cmd` this cycle.
- `drive_state` output, 3 bits: current state (`drive_seq_pkg::state_e`), for debug LEDs.
- `fault` output, 1 bit: high while in FAULT.

## Operation
- Decision decode, sampled only on `frame_tick`:
  - `centered` gives FWD.
  - Otherwise `turn_left` alone gives LEFT, and `turn_right` alone gives RIGHT.
  - Anything else, including left and right both high, gives NEUTRAL.
- Debounce:
  - Registers: `cand` (the candidate decision) and `cnt` (4 bits, saturating at `CONFIRM_FRAMES`).
  - On a tick, if the decision equals `cand`, then `cnt` increments. Otherwise `cand` takes the decision and `cnt` becomes 1.
  - The decision is confirmed when `cnt` reaches `CONFIRM_FRAMES`.
- Neutral run counter: 8 bits, saturating. It increments on each NEUTRAL tick and clears on any non-NEUTRAL tick.
- States and commands:

  | State | Command code |
  |---|---|
  | ST_IDLE | CMD_STOP = 0 |
  | ST_FWD | CMD_FWD = 1 |
  | ST_LEFT | CMD_LEFT = 2 |
  | ST_RIGHT | CMD_RIGHT = 3 |
  | ST_SEARCH | CMD_SPIN = 4 |
  | ST_FAULT | CMD_STOP = 0 |

- Transitions, evaluated on the tick after the counters update:
  - A confirmed FWD, LEFT or RIGHT moves to the matching state from IDLE, FWD, LEFT, RIGHT or SEARCH.
  - A confirmed NEUTRAL moves to IDLE.
  - With the search feature compiled in, a neutral run reaching `LOST_FRAMES` moves to SEARCH. This takes precedence over IDLE.
  - From FAULT, the next `frame_tick` moves to IDLE and clears `cand`, `cnt` and the neutral run; that tick's decision is not counted.
- Command issue:
  - Every state change loads `cmd` with the new state's code and sets `cmd_valid`.
  - `cmd_valid` clears on the cycle after `cmd_valid && cmd_ready`.
  - If a state change happens while a command is still pending, `cmd` is overwritten (latest wins) and `cmd_valid` stays high. The driver samples `cmd` only on the handshake cycle.
  - A self-transition (target equals current state) issues no command.
- Watchdog:
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`. It clears on `frame_tick` and otherwise increments, saturating.
  - Reaching `TIMEOUT_CYCLES` enters FAULT and issues CMD_STOP. This applies from any state except FAULT.
  - If `frame_tick` and the timeout occur in the same cycle, the tick wins and there is no FAULT.

## Timing
- Reset values:
  - `drive_state` = ST_IDLE
  - `cmd` = CMD_STOP
  - `cmd_valid` = 0
  - `fault` = 0
  - All counters at 0; `cand` = NEUTRAL.
- Latency: the state, `cmd`, `cmd_valid` and `fault` update on the cycle after the `frame_tick` or timeout cycle that triggers them (1 cycle).
- With `CONFIRM_FRAMES` = N, a steady new decision takes effect one cycle after the Nth consecutive tick.
- `cmd_ready` held high: `cmd_valid` is high for exactly 1 cycle per change.
- `rst` asserted mid-handshake: `cmd_valid` drops on the next edge and the pending command is lost. This is the intended behaviour, since the motor driver also resets to STOP.
- Flags are ignored on cycles without `frame_tick`.

## Configuration
- `DRIVE_SEQ_SEARCH_EN` defined: ST_SEARCH and the neutral run counter are compiled in, and a lost target triggers CMD_SPIN.
- Not defined:
  - The neutral run counter and ST_SEARCH are removed.
  - NEUTRAL only ever leads to ST_IDLE.
  - CMD_SPIN is never issued.
  - The `state_e` encoding is unchanged.

## Structure
- `drive_seq_pkg` holds:
  - `state_e` (3-bit enum) and `cmd_e` (3-bit enum).
  - `dec_e` (NEUTRAL, FWD, LEFT, RIGHT).
  - The `state_to_cmd` function.
- Sub-module `drive_seq_debounce`: generic N-frame confirmer with inputs `tick`, `dec`, `clear` and outputs `confirmed`, `conf_dec`. It is instantiated once.

## Test plan
- Reset, then 3 ticks with `centered`=1 and `cmd_ready`=1: `drive_state` goes to FWD one cycle after the 3rd tick; `cmd`=1 and `cmd_valid` is high for 1 cycle.
- Ticks alternating `turn_left` and `turn_right` for 10 frames: no state change and no `cmd_valid`.
- `turn_left` and `turn_right` both high for 3 ticks while in FWD: goes to IDLE with `cmd`=0.
- No `frame_tick` for 2_000_000 cycles while in LEFT: `fault`=1 and `cmd`=0; the next tick gives IDLE and `fault`=0. A second case puts a tick on the exact timeout cycle: no FAULT.
- `cmd_ready` held low, then FWD is confirmed followed by RIGHT confirmed: `cmd_valid` stays high and `cmd` changes from 1 to 3. With `cmd_ready` then pulsed, one handshake completes with `cmd`=3.
- With `DRIVE_SEQ_SEARCH_EN`, 8 neutral ticks from FWD: IDLE after tick 3, SEARCH with `cmd`=4 after tick 8. Without the macro, the state stays IDLE.
